// File: rtl/enc_pkg.sv
// Shared constants and helpers for the request priority encoder.
// Helpers work on a fixed maximum width; callers cast to their own width.
package enc_pkg;

    localparam int unsigned NumReqDefault = 8;
    localparam int unsigned CodeWDefault  = $clog2(NumReqDefault);
    localparam int unsigned MaxN          = 64;

    function automatic logic [MaxN-1:0] onehot(input logic [7:0] idx);
        logic [MaxN-1:0] v;
        v = MaxN'(1) << idx;
        return v;
    endfunction

    function automatic logic [7:0] popcount(input logic [MaxN-1:0] v);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(MaxN); i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: lowest set index wins.
module prio_enc_comb #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] in_bits,
    output logic [W-1:0] sel,
    output logic         any
);

    always_comb begin
        sel = '0;
        // Scan high to low so the lowest set index is the last to overwrite sel.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                sel = W'(i);
            end
        end
        any = |in_bits;
    end

endmodule

// File: rtl/req_priority_encoder.sv
// Sticky pending set of request lines, served lowest index first as binary codes
// with a registered valid/ready output and a saturating coalesce counter.
module req_priority_encoder
    import enc_pkg::*;
#(
    parameter int unsigned N    = NumReqDefault,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [$clog2(N)-1:0] out_code,
    output logic [N-1:0]    pending_o,
    output logic [CNTW-1:0] coalesce_cnt
);

    localparam int unsigned W    = $clog2(N);
    localparam int unsigned SumW = CNTW + 8;
    localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

    // The valid flag is the only state: IDLE has no code, HOLD presents one.
    localparam logic StIdle = 1'b0;
    localparam logic StHold = 1'b1;

    logic            state_q, state_d;
    logic [W-1:0]    code_q, code_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic         fire;
    logic         load;
    logic         take;
    logic [W-1:0] sel;
    logic         any;
    logic [N-1:0] remove_mask;
    logic [N-1:0] hits;
    logic [7:0]   hit_cnt;
    logic [SumW-1:0] cnt_sum;

    prio_enc_comb #(
        .N (N),
        .W (W)
    ) u_prio_enc (
        .in_bits (pending_q),
        .sel     (sel),
        .any     (any)
    );

    always_comb begin
        fire = (state_q == StHold) & out_ready;
        load = (state_q == StIdle) | fire;
        take = load & any;
        remove_mask = take ? N'(onehot(8'(sel))) : '0;
        // A request on the bit being removed re-sets it in the same edge.
        pending_d = (pending_q & ~remove_mask) | req_i;
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            StIdle: begin
                if (any) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (fire && !any) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (take) begin
            code_d = sel;
        end
    end

    // Merges only count when the bit stays pending; a remove/request race is a re-arm.
    always_comb begin
        hits    = req_i & pending_q & ~remove_mask;
        hit_cnt = popcount(MaxN'(hits));
        cnt_sum = SumW'(cnt_q) + SumW'(hit_cnt);
        if (cnt_sum > SumW'(CntMax)) begin
            cnt_d = CntMax;
        end else begin
            cnt_d = cnt_sum[CNTW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            code_q    <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid    = state_q;
    assign out_code     = code_q;
    assign pending_o    = pending_q;
    assign coalesce_cnt = cnt_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Scoreboard bench for req_priority_encoder: expected codes queued with stimulus,
// popped by a monitor on every accepted output; scenario tasks check timing inline.
module tb_req_priority_encoder;

    logic       clk;
    logic       reset_n;
    logic [7:0] req_i;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic [7:0] pending_o;
    logic [7:0] coalesce_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic [2:0] exp_q[$];

    req_priority_encoder #(
        .N    (8),
        .CNTW (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_i        (req_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_code     (out_code),
        .pending_o    (pending_o),
        .coalesce_cnt (coalesce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every handshake must match the next queued code.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected code %0d, queue empty", out_code);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (out_code !== e) begin
                    errors++;
                    $display("FAIL scoreboard: code=%0d expected %0d", out_code, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_i     = 8'hFF;
        out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || pending_o !== 8'h00 || coalesce_cnt !== 8'h00
            || out_code !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b pend=%h cnt=%0d code=%0d expected 0 0 0 0",
                     out_valid, pending_o, coalesce_cnt, out_code);
        end
        req_i   = 8'h00;
        reset_n = 1'b1;
        exp_cnt = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || pending_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: valid=%b pend=%h expected 0 00", out_valid, pending_o);
        end
    endtask

    task automatic test_single();
        exp_q.push_back(3'd4);
        out_ready = 1'b1;
        req_i     = 8'h10;
        tick();
        req_i = 8'h00;
        checks++;
        if (out_valid !== 1'b0 || pending_o !== 8'h10) begin
            errors++;
            $display("FAIL single_capture: valid=%b pend=%h expected 0 10", out_valid, pending_o);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd4 || pending_o !== 8'h00) begin
            errors++;
            $display("FAIL single_emit: valid=%b code=%0d pend=%h expected 1 4 00",
                     out_valid, out_code, pending_o);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_multi_hit();
        logic [4:0] exp_valid;
        exp_valid = 5'b01111;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd7);
        out_ready = 1'b1;
        req_i     = 8'hA5;
        tick();
        req_i = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== exp_valid[i]) begin
                errors++;
                $display("FAIL multi_valid[%0d]: valid=%b expected %b", i, out_valid,
                         exp_valid[i]);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL multi_drain: %0d codes left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        out_ready = 1'b0;
        req_i     = 8'h06;
        tick();
        req_i = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_code !== 3'd1 || pending_o !== 8'h04) begin
                errors++;
                $display("FAIL bp_stall[%0d]: valid=%b code=%0d pend=%h expected 1 1 04",
                         i, out_valid, out_code, pending_o);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd2) begin
            errors++;
            $display("FAIL bp_next: valid=%b code=%0d expected 1 2", out_valid, out_code);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_idle: valid=%b left=%0d expected 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_coalesce_race();
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        out_ready = 1'b0;
        req_i     = 8'h03;
        tick();
        req_i = 8'h08;
        tick();
        checks++;
        if (coalesce_cnt !== 8'(exp_cnt) || pending_o !== 8'h0A) begin
            errors++;
            $display("FAIL coal_setup: cnt=%0d pend=%h expected %0d 0a", coalesce_cnt,
                     pending_o, exp_cnt);
        end
        // Bits 1 and 3 requested again while pending during a stall.
        req_i = 8'h0A;
        tick();
        exp_cnt = exp_cnt + 2;
        checks++;
        if (coalesce_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL coal_merge: cnt=%0d expected %0d", coalesce_cnt, exp_cnt);
        end
        req_i     = 8'h00;
        out_ready = 1'b1;
        tick();
        // Code 3 is loaded this edge while bit 3 is requested again.
        req_i = 8'h08;
        tick();
        req_i = 8'h00;
        checks++;
        if (out_code !== 3'd3 || pending_o !== 8'h08 || coalesce_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL coal_race: code=%0d pend=%h cnt=%0d expected 3 08 %0d",
                     out_code, pending_o, coalesce_cnt, exp_cnt);
        end
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL coal_drain: valid=%b left=%0d expected 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        req_i     = 8'hFF;
        tick();
        tick();
        // First load removes bit 0, so only seven bits merge on that edge.
        exp_cnt = exp_cnt + 7;
        checks++;
        if (coalesce_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL sat_first: cnt=%0d expected %0d", coalesce_cnt, exp_cnt);
        end
        for (int i = 0; i < 38; i++) begin
            tick();
            exp_cnt = (exp_cnt + 8 > 255) ? 255 : exp_cnt + 8;
            checks++;
            if (coalesce_cnt !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_step[%0d]: cnt=%0d expected %0d", i, coalesce_cnt, exp_cnt);
            end
        end
        req_i = 8'h00;
        exp_q.push_back(3'd0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(3'(i));
        end
        out_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0 || coalesce_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL sat_drain: valid=%b left=%0d cnt=%0d expected 0 0 255",
                     out_valid, exp_q.size(), coalesce_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        req_i     = 8'hF8;
        tick();
        req_i = 8'h00;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd3 || pending_o !== 8'hF0) begin
            errors++;
            $display("FAIL mid_setup: valid=%b code=%0d pend=%h expected 1 3 f0",
                     out_valid, out_code, pending_o);
        end
        reset_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if (out_valid !== 1'b0 || out_code !== 3'd0 || pending_o !== 8'h00
            || coalesce_cnt !== 8'h00) begin
            errors++;
            $display("FAIL mid_async: valid=%b code=%0d pend=%h cnt=%0d expected 0 0 00 0",
                     out_valid, out_code, pending_o, coalesce_cnt);
        end
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || pending_o !== 8'h00) begin
                errors++;
                $display("FAIL mid_after[%0d]: valid=%b pend=%h expected 0 00", i,
                         out_valid, pending_o);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_i     = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi_hit();
        test_backpressure();
        test_coalesce_race();
        test_saturate();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
